// File: rtl/scratchpad_key_loader.sv
// rtl/scratchpad_key_loader.sv - TL-UL Get master streaming scratchpad key words
//
// Reads word_count_i consecutive 64-bit words from the LLKI scratchpad,
// starting at base_addr_i (8-byte aligned), and delivers them in order on a
// valid/ready key stream. Up to MAX_OUTSTANDING Gets are in flight. A Get is
// only issued once a response buffer slot is reserved for it, so the D channel
// is never back-pressured.
//
// Optional feature: define SCRATCHPAD_KEY_LOADER_CHECKSUM_EN to add checksum_o,
// the XOR of every word popped on the key stream during the current run.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i                  one-cycle run request (taken only when idle)
//   base_addr_i              byte address of first word (bits [2:0] ignored)
//   word_count_i             words to read, 0 = immediate done
//   busy_o, done_o, error_o  run status; error_o is sticky until next start
//   key_data_o/valid/ready   output word stream
//   checksum_o               (optional) XOR of delivered words
//   master_a_*               TL-UL A channel (Get requests)
//   master_d_*               TL-UL D channel (AccessAckData responses)

module scratchpad_key_loader #(
  parameter int ADDR_W          = 32,
  parameter int CNT_W           = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int RSP_DEPTH       = 4,
  parameter int TL_SZW          = 2,
  parameter int TL_AIW          = 8,
  parameter int TL_DIW          = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  word_count_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [63:0]       key_data_o,
  output logic              key_valid_o,
  input  logic              key_ready_i,
`ifdef SCRATCHPAD_KEY_LOADER_CHECKSUM_EN
  output logic [63:0]       checksum_o,
`endif
  output logic [2:0]        master_a_opcode,
  output logic [2:0]        master_a_param,
  output logic [TL_SZW-1:0] master_a_size,
  output logic [TL_AIW-1:0] master_a_source,
  output logic [ADDR_W-1:0] master_a_address,
  output logic [7:0]        master_a_mask,
  output logic [63:0]       master_a_data,
  output logic              master_a_corrupt,
  output logic              master_a_valid,
  input  logic              master_a_ready,
  input  logic [2:0]        master_d_opcode,
  input  logic [2:0]        master_d_param,
  input  logic [TL_SZW-1:0] master_d_size,
  input  logic [TL_AIW-1:0] master_d_source,
  input  logic [TL_DIW-1:0] master_d_sink,
  input  logic              master_d_denied,
  input  logic              master_d_corrupt,
  input  logic [63:0]       master_d_data,
  input  logic              master_d_valid,
  output logic              master_d_ready
);

  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FCW = $clog2(RSP_DEPTH + 1);
  localparam int PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  issue_left;
  logic [CNT_W-1:0]  recv_left;
  logic [OW-1:0]     outstanding;
  logic              error_q;
  logic              zero_done_q;

  logic [63:0]       mem [RSP_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [FCW-1:0]    fifo_cnt;

  logic accept, a_fire, d_take, d_good, push, pop, room;

  // Fixed Get request fields.
  assign master_a_opcode  = 3'h4;
  assign master_a_param   = 3'h0;
  assign master_a_size    = TL_SZW'(3);
  assign master_a_source  = '0;
  assign master_a_mask    = 8'hFF;
  assign master_a_data    = 64'h0;
  assign master_a_corrupt = 1'b0;
  assign master_a_address = addr;
  assign master_d_ready   = rst_ni;

  logic unused_inputs;
  assign unused_inputs = ^{master_d_param, master_d_size, master_d_source,
                           master_d_sink, base_addr_i[2:0]};

  assign accept = (state == IDLE) && start_i;
  // Responses with nothing outstanding are stale (e.g. from before a reset).
  assign d_take = master_d_valid && (outstanding != '0);
  assign d_good = (master_d_opcode == 3'h1) && !master_d_denied && !master_d_corrupt;
  assign push   = d_take && d_good;
  assign key_valid_o = (fifo_cnt != '0);
  assign key_data_o  = key_valid_o ? mem[rd_ptr] : 64'h0;
  assign pop    = key_valid_o && key_ready_i;

  // Every in-flight Get owns a buffer slot, so a response can always be stored.
  // The condition only becomes false through issuing, hence a_valid is never
  // withdrawn before acceptance.
  always_comb begin
    room = ((int'(outstanding) + int'(fifo_cnt)) < RSP_DEPTH) &&
           (int'(outstanding) < MAX_OUTSTANDING);
  end

  assign master_a_valid = (state == ISSUE) && room;
  assign a_fire         = master_a_valid && master_a_ready;
  assign busy_o         = (state == ISSUE) || (state == DRAIN);
  assign done_o         = (state == DONE) || zero_done_q;
  assign error_o        = error_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      addr        <= '0;
      issue_left  <= '0;
      recv_left   <= '0;
      outstanding <= '0;
      error_q     <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      zero_done_q <= accept && (word_count_i == '0);

      if (d_take) recv_left <= recv_left - 1'b1;

      case (state)
        IDLE: begin
          if (accept && (word_count_i != '0)) begin
            addr       <= {base_addr_i[ADDR_W-1:3], 3'b000};
            issue_left <= word_count_i;
            recv_left  <= word_count_i;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (a_fire) begin
            addr       <= addr + ADDR_W'(8);
            issue_left <= issue_left - 1'b1;
            if (issue_left == CNT_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((recv_left == '0) && (fifo_cnt == '0)) state <= DONE;
        end
        default: state <= IDLE;
      endcase

      case ({a_fire, d_take})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase

      // Setting wins over the start clear so a same-cycle bad response is kept.
      if (accept) error_q <= 1'b0;
      if (master_d_valid && ((outstanding == '0) || !d_good)) error_q <= 1'b1;
    end
  end

  // Response buffer pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= master_d_data;
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && !pop && (fifo_cnt == FCW'(RSP_DEPTH))));

`ifdef SCRATCHPAD_KEY_LOADER_CHECKSUM_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      checksum_o <= 64'h0;
    end else if (accept) begin
      checksum_o <= 64'h0;
    end else if (pop) begin
      checksum_o <= checksum_o ^ key_data_o;
    end
  end
`endif

endmodule

// File: doc/scratchpad_key_loader.md
Name: scratchpad_key_loader

Overview:
- TL-UL host that reads a contiguous run of 64-bit words from the LLKI scratchpad over its flattened TL-UL slave interface.
- Consumes the scratchpad D channel and delivers the words, in order, as a valid/ready stream to a core's key-load logic.
- Keeps a bounded number of Get requests in flight. Reserves response-buffer space before each issue, so d_ready is never deasserted.

Parameters:
- ADDR_W, 32, TL-UL address width (matches top_pkg::TL_AW).
- CNT_W, 8, width of the word-count field; max run of 2^CNT_W-1 words.
- MAX_OUTSTANDING, 4, max Get requests issued but not yet answered.
- RSP_DEPTH, 4, response buffer depth in words; must be >= MAX_OUTSTANDING.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset. Asynchronous assert, active-low.
- start_i  in  1  one-cycle pulse; ignored unless busy_o=0.
- base_addr_i  in  ADDR_W  byte address of first word; bits[2:0] ignored, forced to 0.
- word_count_i  in  CNT_W  number of words to read; 0 = immediate done.
- busy_o  out  1  run in progress.
- done_o  out  1  one-cycle pulse at end of run.
- error_o  out  1  sticky: a response of the last run was denied, corrupt or wrong opcode. Cleared on next accepted start.
- key_data_o  out  64  word stream data.
- key_valid_o  out  1  stream valid.
- key_ready_i  in  1  stream ready.
- master_a_opcode  out  3  always 3'h4 (Get).
- master_a_param  out  3  0.
- master_a_size  out  TL_SZW  3 (8 bytes).
- master_a_source  out  TL_AIW  0.
- master_a_address  out  ADDR_W  current request address.
- master_a_mask  out  8  8'hFF.
- master_a_data  out  64  0.
- master_a_corrupt  out  1  0.
- master_a_valid  out  1  request valid.
- master_a_ready  in  1  request accepted.
- master_d_opcode  in  3  expect 3'h1 (AccessAckData).
- master_d_denied, master_d_corrupt  in  1  error indicators.
- master_d_data  in  64  read data.
- master_d_valid  in  1  response valid.
- master_d_ready  out  1  tied 1 while out of reset.
- Unused D fields (param, size, source, sink) are inputs and are ignored.

Behaviour:
- Reset values: busy_o, done_o, error_o, key_valid_o, master_a_valid all 0. key_data_o 0. master_d_ready 0 during reset, 1 after. State IDLE. All counters 0.
- FSM states:
  - IDLE: start_i with word_count_i!=0 loads addr=base&~7, issue_left=word_count_i, recv_left=word_count_i; clears error_o; goes to ISSUE. start_i with word_count_i==0 pulses done_o next cycle and stays IDLE.
  - ISSUE: master_a_valid=1 iff outstanding + buffered < RSP_DEPTH and outstanding < MAX_OUTSTANDING. On a_valid&a_ready: addr+=8, issue_left--, outstanding++. issue_left reaching 0 moves to DRAIN.
  - DRAIN: a_valid=0. When recv_left==0 and the buffer is empty, goes to DONE.
  - DONE: done_o=1 for one cycle, busy_o=0 next, returns to IDLE.
- busy_o=1 in ISSUE and DRAIN.
- master_a_valid is held with stable address until accepted; it is never withdrawn.
- Any d_valid: outstanding--, recv_left--.
  - Good response (opcode 3'h1, no denied, no corrupt): data pushed into the buffer.
  - Otherwise: data discarded, error_o set.
- Same-cycle a-accept and d-receive: outstanding unchanged.
- Buffer is an in-order FIFO driving key_*. Same-cycle push and pop allowed when full.
- The reservation rule makes overflow impossible. A push to a full buffer is a design bug; flag it with an assertion.
- Address increment wraps modulo 2^ADDR_W; no error.
- d_valid arriving while outstanding==0 is ignored; error_o is set.
- start_i while busy is ignored.
- Reset mid-run discards all state. In-flight responses arriving after reset release are absorbed by the outstanding==0 rule.
- Latency: first a_valid is asserted the cycle after start_i. First key_valid_o is asserted the cycle after the first good d_valid.

Optional Feature:
- Macro: SCRATCHPAD_KEY_LOADER_CHECKSUM_EN.
- When defined: adds output checksum_o [63:0]. It is the XOR of all words popped on the key stream in the current run. Cleared to 0 on accepted start; valid when done_o pulses.
- When undefined: port and logic absent.

Test Plan:
- base=0x100, count=4, scratchpad holds 0x11..0x44, key_ready=1 -> Gets to 0x100,0x108,0x110,0x118; stream 0x11,0x22,0x33,0x44; done_o pulse; error_o=0.
- count=10, key_ready=0 throughout -> exactly 4 Gets issued then a_valid=0; raise key_ready -> all 10 words delivered in order.
- count=3, second response d_denied=1 -> stream delivers words 1 and 3 only; done_o pulses with error_o=1; next start clears error_o.
- a_ready held 0 for 5 cycles -> a_valid stays 1, address 0x100 stable; then proceeds normally.
- count=0 -> done_o one cycle after start, no a_valid. Reset asserted mid-run (2 of 6 words delivered) -> all outputs return to reset values; fresh start works.
- With CHECKSUM_EN, words 0xF0,0x0F,0xFF -> checksum_o=0x00 at done_o.
